// File: rtl/wave_envelope_adsr.sv
// rtl/wave_envelope_adsr.sv - ADSR amplitude envelope with registered sample scaling
module wave_envelope_adsr #(
   parameter int DATA_W = 8,
   parameter int ENV_W  = 8,
   parameter int RATE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gate,
   input  logic [RATE_W-1:0] attack_rate,
   input  logic [RATE_W-1:0] decay_rate,
   input  logic [ENV_W-1:0]  sustain_level,
   input  logic [RATE_W-1:0] release_rate,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_out_valid,
   output logic [ENV_W-1:0]  env_level,
   output logic [2:0]        env_state,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam logic [ENV_W-1:0] ENV_MAX = '1;
   localparam logic [ENV_W-1:0] ENV_MIN = '0;

   state_t              state;
   logic [RATE_W-1:0]   rate_cnt;
   logic [RATE_W-1:0]   cur_rate;
   logic                step;

   logic [ENV_W:0]          env_plus1;
   logic [DATA_W+ENV_W-1:0] product;
   logic [ENV_W-1:0]        unused_frac;

   always_comb begin
      cur_rate = '0;
      case (state)
         S_ATTACK:  cur_rate = attack_rate;
         S_DECAY:   cur_rate = decay_rate;
         S_RELEASE: cur_rate = release_rate;
         default:   cur_rate = '0;
      endcase
   end

   assign step      = (rate_cnt == cur_rate);
   assign env_state = state;
   assign busy      = (state != S_IDLE);

   // Gate is checked first in every state; any state change also clears rate_cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         env_level <= '0;
         rate_cnt  <= '0;
      end else begin
         rate_cnt <= step ? '0 : rate_cnt + 1'b1;
         case (state)
            S_IDLE: begin
               if (gate) begin
                  state    <= S_ATTACK;
                  rate_cnt <= '0;
               end else begin
                  env_level <= '0;
               end
            end
            S_ATTACK: begin
               if (!gate) begin
                  state    <= S_RELEASE;
                  rate_cnt <= '0;
               end else if (env_level == ENV_MAX) begin
                  state    <= S_DECAY;
                  rate_cnt <= '0;
               end else if (step) begin
                  env_level <= env_level + 1'b1;
               end
            end
            S_DECAY: begin
               if (!gate) begin
                  state    <= S_RELEASE;
                  rate_cnt <= '0;
               end else if (env_level <= sustain_level) begin
                  state    <= S_SUSTAIN;
                  rate_cnt <= '0;
               end else if (step) begin
                  env_level <= env_level - 1'b1;
               end
            end
            S_SUSTAIN: begin
               if (!gate) begin
                  state    <= S_RELEASE;
                  rate_cnt <= '0;
               end else begin
                  env_level <= sustain_level;
               end
            end
            S_RELEASE: begin
               if (gate) begin
                  state    <= S_ATTACK;
                  rate_cnt <= '0;
               end else if (env_level == ENV_MIN) begin
                  state    <= S_IDLE;
                  rate_cnt <= '0;
               end else if (step) begin
                  env_level <= env_level - 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               rate_cnt <= '0;
            end
         endcase
      end
   end

   // Scaling by level+1 makes full scale pass samples through unchanged;
   // the product never needs more than DATA_W+ENV_W bits.
   assign env_plus1 = {1'b0, env_level} + {{ENV_W{1'b0}}, 1'b1};
   assign product   = {{ENV_W{1'b0}}, sample_in} * {{(DATA_W-1){1'b0}}, env_plus1};
   assign unused_frac = product[ENV_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_out       <= '0;
         sample_out_valid <= 1'b0;
      end else begin
         sample_out_valid <= sample_valid;
         if (sample_valid) begin
            sample_out <= product[DATA_W+ENV_W-1:ENV_W];
         end
      end
   end

endmodule
